pool_sched: RTL and testbench
=============================

Name: pool_sched

Overview:
- Sequencer for the 2x2/stride-2 max-pool stage of the CONV engine.
- Reads the convolution result map (layer0, IN_DIM x IN_DIM) over the shared layer-memory bus and writes the pooled map (layer1, IN_DIM/2 x IN_DIM/2).
- Contains the window address counters, a one-register running-max datapath, and a req/gnt handshake to the bus arbiter.
- Started by the top-level control FSM after the conv write phase; reports done back to it.

Parameters:
- DATA_W, 20, sample width (signed, 4.16 fixed point)
- IN_DIM, 64, layer0 side length (power of two, >=4)
- AW, 12, read/write address width (>= 2*log2(IN_DIM))

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle pulse; begin pooling pass
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final layer1 write
- mem_req  out  1  bus request
- mem_gnt  in  1  bus grant
- win_active  out  1  high while a window is in flight; arbiter must not change mem_gnt while high
- csel  out  3  001 = layer0 read, 011 = layer1 write, 000 = idle
- crd  out  1  read strobe
- caddr_rd  out  AW  read address
- cdata_rd  in  DATA_W  read data, valid exactly 1 cycle after crd
- cwr  out  1  write strobe
- caddr_wr  out  AW  write address
- cdata_wr  out  DATA_W  write data

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset, applied any cycle including mid-window:
  - state goes to IDLE.
  - busy, done, mem_req, win_active, crd and cwr are 0; csel = 000.
  - Addresses, cdata_wr, the window counters (r, c), the sample counter k and the max register are all 0.
- States: IDLE, ARB, READ, DRAIN, WRITE.
- IDLE:
  - start=1 -> ARB; r = c = 0.
  - start is ignored in every other state.
- ARB:
  - mem_req=1, win_active=0.
  - mem_gnt=1 -> READ with k=0; otherwise stay in ARB.
  - mem_gnt is sampled only here.
- READ (4 cycles, k = 0..3):
  - crd=1, csel=001.
  - caddr_rd = base + {0, 1, IN_DIM, IN_DIM+1}[k], where base = 2r*IN_DIM + 2c.
  - After k=3 -> DRAIN.
- Max capture, each cycle following a crd cycle (READ k>=1, and DRAIN):
  - first sample of the window loads max unconditionally.
  - later samples replace max only if strictly greater, using signed compare.
- DRAIN (1 cycle): captures sample 3; crd=0.
- WRITE (1 cycle):
  - cwr=1, csel=011, caddr_wr = r*(IN_DIM/2) + c, cdata_wr = max.
  - Then advance c; when c wraps from IN_DIM/2-1 to 0, increment r.
  - If this was window (IN_DIM/2-1, IN_DIM/2-1): -> IDLE, with done=1 and busy=0 in the following cycle.
  - Otherwise -> ARB.
- Outputs in ARB/READ/DRAIN/WRITE: mem_req=1; win_active=1 in READ/DRAIN/WRITE.
- Latency:
  - 7 cycles per window with mem_gnt held high.
  - Full pass at IN_DIM=64: 1024*7 = 7168 cycles from the first ARB cycle to done.
- Unused addr/data outputs hold their last value; only the strobes qualify them.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: each captured sample is clamped to 0 if negative before the compare. Layer1 values are therefore >= 0.
- Undefined: raw signed compare. Negative maxima are written unchanged.

Decomposition:
- Shared package/def file holds:
  - state encodings (one-hot, index constants)
  - csel codes CSEL_IDLE / CSEL_L0 / CSEL_L1
  - default DATA_W and IN_DIM
- One sub-module: pool_max_reg, the capture/compare register with load-first, strict-greater update and optional ReLU clamp.
- FSM, counters and address generation stay in pool_sched.

Test Plan:
- Address/data check:
  - Stimulus: mem_gnt tied 1; layer0[a] = a; start.
  - Required: first reads are 0, 1, 64, 65.
  - Required: layer1[0]=65, layer1[1]=67, layer1[31]=127, layer1[32]=193, layer1[1023]=4095.
  - Required: write addresses 0..1023 in order; done exactly 7168 cycles after the first ARB cycle.
- Negative window:
  - Stimulus: window 0 = {-1, -5, -3, -2} (20-bit two's complement).
  - Required: layer1[0] = -1 without POOL_RELU_EN; 0 with it.
- Ties: window = {7, 7, 7, 7} -> layer1 = 7; exactly one cwr for the window.
- Grant stall:
  - Stimulus: deassert mem_gnt for 10 cycles while in ARB before window 5.
  - Required: crd = cwr = 0 and mem_req=1 throughout the stall; pass resumes; final layer1 contents identical to the unstalled run; done delayed by 10 cycles.
- Start while busy: extra start pulse while busy -> ignored; exactly 1024 writes and a single done pulse.
- Reset mid-window:
  - Stimulus: assert reset during READ k=2 of window 100.
  - Required: next cycle all strobes, busy and done = 0, csel=000.
  - Required: subsequent start completes a full correct pass from window 0.

Source files
------------

// File: rtl/pool_sched_pkg.sv
// pool_sched_pkg: shared definitions for the 2x2/stride-2 max-pool sequencer.
// Holds default sizes, one-hot FSM state encodings and bus select codes.
package pool_sched_pkg;

    // Default datapath / map sizes
    localparam int DATA_W_DEF = 20;
    localparam int IN_DIM_DEF = 64;
    localparam int AW_DEF     = 12;

    // One-hot state bit positions
    localparam int ST_IDLE  = 0;
    localparam int ST_ARB   = 1;
    localparam int ST_READ  = 2;
    localparam int ST_DRAIN = 3;
    localparam int ST_WRITE = 4;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ARB   = 5'b00010,
        S_READ  = 5'b00100,
        S_DRAIN = 5'b01000,
        S_WRITE = 5'b10000
    } state_e;

    // Layer-memory bus select codes
    localparam logic [2:0] CSEL_IDLE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

endpackage

// File: rtl/pool_max_reg.sv
// pool_max_reg: running-max register for one 2x2 pooling window.
// Ports: clk, reset (sync, active-high); cap_en captures sample this cycle;
// cap_first loads unconditionally (first sample of a window);
// sample is the signed input; max_nxt is the value max holds after this edge.
// Optional: define POOL_RELU_EN to clamp negative samples to 0 before compare.
module pool_max_reg
    import pool_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en,
    input  logic              cap_first,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] max_nxt
);

    logic signed [DATA_W-1:0] s_in;
    logic signed [DATA_W-1:0] max_q;

    always_comb begin
        s_in = $signed(sample);
`ifdef POOL_RELU_EN
        if (s_in[DATA_W-1])
            s_in = '0;
`endif
    end

    // Ties keep the held value: only a strictly greater sample replaces it.
    always_comb begin
        max_nxt = max_q;
        if (cap_en && (cap_first || (s_in > max_q)))
            max_nxt = s_in;
    end

    always_ff @(posedge clk) begin
        if (reset)
            max_q <= '0;
        else
            max_q <= max_nxt;
    end

endmodule

// File: rtl/pool_sched.sv
// pool_sched: 2x2/stride-2 max-pool sequencer, layer0 (IN_DIMxIN_DIM) to
// layer1 (IN_DIM/2 square) over the shared layer-memory bus.
// Ports: clk, reset (sync, active-high), start pulse, busy, done pulse;
// mem_req/mem_gnt arbiter handshake, win_active (grant must stay stable);
// csel bus select, crd/caddr_rd/cdata_rd read port (data 1 cycle after crd),
// cwr/caddr_wr/cdata_wr write port.
// Optional: POOL_RELU_EN (in pool_max_reg) clamps negative samples to 0.
module pool_sched
    import pool_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IN_DIM = IN_DIM_DEF,
    parameter int AW     = AW_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              win_active,
    output logic [2:0]        csel,
    output logic              crd,
    output logic [AW-1:0]     caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [AW-1:0]     caddr_wr,
    output logic [DATA_W-1:0] cdata_wr
);

    localparam int LG = $clog2(IN_DIM);
    localparam int HW = LG - 1;
    localparam int WA = 2 * HW;

    state_e          state;
    logic [HW-1:0]   r;
    logic [HW-1:0]   c;
    logic [1:0]      k;
    logic [1:0]      k_inc;
    logic [WA-1:0]   win_nxt;
    logic            last_win;
    logic            cap_en;
    logic            cap_first;
    logic [DATA_W-1:0] max_nxt;

    assign k_inc    = k + 2'd1;
    assign win_nxt  = {r, c} + WA'(1);
    assign last_win = &{r, c};

    // Read data lands one cycle after each crd: READ k=1..3 and DRAIN.
    assign cap_en    = (state == S_READ && k != 2'd0) || (state == S_DRAIN);
    assign cap_first = (state == S_READ && k == 2'd1);

    pool_max_reg #(
        .DATA_W    (DATA_W)
    ) u_max (
        .clk       (clk),
        .reset     (reset),
        .cap_en    (cap_en),
        .cap_first (cap_first),
        .sample    (cdata_rd),
        .max_nxt   (max_nxt)
    );

    // IN_DIM is a power of two, so base + {0,1,IN_DIM,IN_DIM+1}[k]
    // is the bit concatenation {r, k[1], c, k[0]}; the write address
    // r*(IN_DIM/2)+c is {r, c}.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_req    <= 1'b0;
            win_active <= 1'b0;
            csel       <= CSEL_IDLE;
            crd        <= 1'b0;
            cwr        <= 1'b0;
            caddr_rd   <= '0;
            caddr_wr   <= '0;
            cdata_wr   <= '0;
            r          <= '0;
            c          <= '0;
            k          <= '0;
        end else begin
            done <= 1'b0;
            unique case (1'b1)
                state[ST_IDLE]: begin
                    if (start) begin
                        state   <= S_ARB;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        r       <= '0;
                        c       <= '0;
                    end
                end
                state[ST_ARB]: begin
                    if (mem_gnt) begin
                        state      <= S_READ;
                        k          <= 2'd0;
                        crd        <= 1'b1;
                        csel       <= CSEL_L0;
                        win_active <= 1'b1;
                        caddr_rd   <= AW'({r, 1'b0, c, 1'b0});
                    end
                end
                state[ST_READ]: begin
                    if (k == 2'd3) begin
                        state <= S_DRAIN;
                        crd   <= 1'b0;
                        csel  <= CSEL_IDLE;
                    end else begin
                        k        <= k_inc;
                        caddr_rd <= AW'({r, k_inc[1], c, k_inc[0]});
                    end
                end
                state[ST_DRAIN]: begin
                    // max_nxt already includes the last sample.
                    state    <= S_WRITE;
                    cwr      <= 1'b1;
                    csel     <= CSEL_L1;
                    caddr_wr <= AW'({r, c});
                    cdata_wr <= max_nxt;
                end
                state[ST_WRITE]: begin
                    cwr        <= 1'b0;
                    csel       <= CSEL_IDLE;
                    win_active <= 1'b0;
                    {r, c}     <= win_nxt;
                    if (last_win) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                    end else begin
                        state <= S_ARB;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_sched.sv
// tb_pool_sched: self-checking bench for pool_sched with a layer-memory
// model, a window-max reference model, vector tables and corner sequences.
module tb_pool_sched;

    localparam int DATA_W = 20;
    localparam int IN_DIM = 64;
    localparam int AW     = 12;
    localparam int HALF   = IN_DIM / 2;
    localparam int NWIN   = HALF * HALF;
    localparam int NL0    = IN_DIM * IN_DIM;
    localparam int PASS_CYC = NWIN * 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_req;
    logic              mem_gnt;
    logic              win_active;
    logic [2:0]        csel;
    logic              crd;
    logic [AW-1:0]     caddr_rd;
    logic [DATA_W-1:0] cdata_rd = '0;
    logic              cwr;
    logic [AW-1:0]     caddr_wr;
    logic [DATA_W-1:0] cdata_wr;

    pool_sched #(
        .DATA_W     (DATA_W),
        .IN_DIM     (IN_DIM),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .win_active (win_active),
        .csel       (csel),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cdata_rd   (cdata_rd),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] layer0 [NL0];
    logic [DATA_W-1:0] layer1 [NWIN];
    int wr_cnt [NWIN];
    int rd_q [$];
    int wr_q [$];
    int cyc = 0;
    int t_arb;
    int t_done;
    int done_cnt;
    int strobe_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string name;
        bit    is_rd;
        int    idx;
        int    exp;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory read port: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (crd)
            cdata_rd <= layer0[caddr_rd];
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (busy && t_arb < 0)
            t_arb = cyc;
        if (done) begin
            done_cnt++;
            t_done = cyc;
        end
        if (crd) begin
            rd_q.push_back(int'(caddr_rd));
            if (csel != 3'b001 || !win_active || cwr || !mem_req)
                strobe_err++;
        end
        if (cwr) begin
            wr_q.push_back(int'(caddr_wr));
            if (int'(caddr_wr) < NWIN) begin
                layer1[caddr_wr[9:0]] = cdata_wr;
                wr_cnt[caddr_wr[9:0]]++;
            end
            if (csel != 3'b011 || !win_active || !mem_req)
                strobe_err++;
        end
        if (busy && done)
            strobe_err++;
    end

    // Reference: max of the 2x2 window at (r, c), straight from the rules.
    function automatic int ref_max(input int w);
        int r;
        int c;
        int base;
        int offs [4];
        logic signed [DATA_W-1:0] best;
        logic signed [DATA_W-1:0] s;
        r = w / HALF;
        c = w % HALF;
        base = 2 * r * IN_DIM + 2 * c;
        offs = '{0, 1, IN_DIM, IN_DIM + 1};
        best = '0;
        for (int i = 0; i < 4; i++) begin
            s = layer0[base + offs[i]];
`ifdef POOL_RELU_EN
            if (s < 0)
                s = '0;
`endif
            if (i == 0 || s > best)
                best = s;
        end
        return int'(best);
    endfunction

    task automatic clear_log();
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < NWIN; i++) begin
            wr_cnt[i] = 0;
            layer1[i] = '0;
        end
        t_arb = -1;
        t_done = -1;
        done_cnt = 0;
        strobe_err = 0;
    endtask

    task automatic run_pass(input string tag, input bit stall,
                            input bit extra_start);
        int n;
        int bad;
        int first_bad;
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (extra_start) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (stall) begin
            n = 0;
            while (!(cwr && caddr_wr == AW'(4)) && n < 1000) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_stall_reached"}, int'(n < 1000), 1);
            mem_gnt = 1'b0;
            bad = 0;
            for (int i = 0; i < 11; i++) begin
                @(negedge clk);
                if (crd || cwr || !mem_req)
                    bad++;
            end
            chk({tag, "_stall_strobes"}, bad, 0);
            mem_gnt = 1'b1;
        end
        n = 0;
        while (!done && n < PASS_CYC + 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_time"}, int'(done), 1);
        repeat (10) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_latency"}, t_done - t_arb,
            PASS_CYC + (stall ? 10 : 0));
        chk({tag, "_write_count"}, wr_q.size(), NWIN);
        bad = 0;
        for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i] != i)
                bad++;
        chk({tag, "_write_order"}, bad, 0);
        bad = 0;
        first_bad = -1;
        for (int w = 0; w < NWIN; w++) begin
            if (wr_cnt[w] != 1 ||
                int'($signed(layer1[w])) != ref_max(w)) begin
                bad++;
                if (first_bad < 0)
                    first_bad = w;
            end
        end
        chk({tag, "_layer1_bad_entries"}, bad, 0);
        if (first_bad >= 0)
            chk({tag, "_first_bad_value"},
                int'($signed(layer1[first_bad])), ref_max(first_bad));
        chk({tag, "_strobe_errors"}, strobe_err, 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        int act;
        tbl[0] = '{name: "rd0",       is_rd: 1, idx: 0,    exp: 0};
        tbl[1] = '{name: "rd1",       is_rd: 1, idx: 1,    exp: 1};
        tbl[2] = '{name: "rd2",       is_rd: 1, idx: 2,    exp: 64};
        tbl[3] = '{name: "rd3",       is_rd: 1, idx: 3,    exp: 65};
        tbl[4] = '{name: "l1_0",      is_rd: 0, idx: 0,    exp: 65};
        tbl[5] = '{name: "l1_1",      is_rd: 0, idx: 1,    exp: 67};
        tbl[6] = '{name: "l1_31",     is_rd: 0, idx: 31,   exp: 127};
        tbl[7] = '{name: "l1_32",     is_rd: 0, idx: 32,   exp: 193};
        tbl[8] = '{name: "l1_1023",   is_rd: 0, idx: 1023, exp: 4095};

        reset = 1'b1;
        start = 1'b0;
        mem_gnt = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_win_active", int'(win_active), 0);
        chk("rst_strobes", int'({crd, cwr}), 0);
        chk("rst_csel", int'(csel), 0);
        chk("rst_addr", int'(caddr_rd) + int'(caddr_wr), 0);
        chk("rst_wdata", int'(cdata_wr), 0);
        reset = 1'b0;

        // Ramp map: layer0[a] = a.
        for (int a = 0; a < NL0; a++)
            layer0[a] = DATA_W'(a);
        run_pass("ramp", 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].is_rd)
                act = (tbl[i].idx < rd_q.size()) ? rd_q[tbl[i].idx] : -1;
            else
                act = int'(layer1[tbl[i].idx]);
            chk({"ramp_", tbl[i].name}, act, tbl[i].exp);
        end

        // Random map with a negative window, a tie window,
        // a grant stall before window 5 and a start while busy.
        for (int a = 0; a < NL0; a++)
            layer0[a] = DATA_W'($urandom);
        layer0[0]  = DATA_W'(-1);
        layer0[1]  = DATA_W'(-5);
        layer0[64] = DATA_W'(-3);
        layer0[65] = DATA_W'(-2);
        layer0[2]  = DATA_W'(7);
        layer0[3]  = DATA_W'(7);
        layer0[66] = DATA_W'(7);
        layer0[67] = DATA_W'(7);
        run_pass("rand", 1'b1, 1'b1);
`ifdef POOL_RELU_EN
        chk("neg_window", int'($signed(layer1[0])), 0);
`else
        chk("neg_window", int'($signed(layer1[0])), -1);
`endif
        chk("tie_value", int'(layer1[1]), 7);
        chk("tie_writes", wr_cnt[1], 1);

        // Reset during READ k=2 of window 100 (r=3, c=4 -> addr 456).
        for (int a = 0; a < NL0; a++)
            layer0[a] = DATA_W'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(crd && caddr_rd == AW'(456)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reset_reached", int'(n < 2000), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_strobes", int'({crd, cwr, mem_req, win_active}), 0);
        chk("mid_reset_busy_done", int'({busy, done}), 0);
        chk("mid_reset_csel", int'(csel), 0);
        reset = 1'b0;
        run_pass("after_reset", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
